// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, ALU op
// classes, datapath mux selects and the control FSM state encoding.
package cpu_pkg;

   localparam int unsigned OPC_W = 7;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 8;

   // Supported major opcodes
   localparam logic [OPC_W-1:0] OPC_RTYPE  = 7'b0110011;
   localparam logic [OPC_W-1:0] OPC_ITYPE  = 7'b0010011;
   localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;

   // Supported branch conditions
   localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
   localparam logic [F3_W-1:0] F3_BNE = 3'b001;

   // aluop classes handed to ALUcontrol
   localparam logic [SEL_W-1:0] ALU_ADD   = 2'b00;
   localparam logic [SEL_W-1:0] ALU_SUB   = 2'b01;
   localparam logic [SEL_W-1:0] ALU_RTYPE = 2'b10;
   localparam logic [SEL_W-1:0] ALU_ITYPE = 2'b11;

   // ALU operand A select
   localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
   localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b01;
   localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b10;

   // ALU operand B select
   localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b10;

   // Register file write-back source
   localparam logic [SEL_W-1:0] WB_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] WB_MDR    = 2'b01;
   localparam logic [SEL_W-1:0] WB_PC     = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WR   = 4'd6,
      S_WB_ALU   = 4'd7,
      S_WB_MEM   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_TRAP     = 4'd11
   } state_e;

   // Dispatch target out of DECODE; unsupported opcodes go to TRAP
   function automatic state_e decode_next(input logic [OPC_W-1:0] opc);
      state_e nxt;
      case (opc)
         OPC_RTYPE:           nxt = S_EXEC_R;
         OPC_ITYPE:           nxt = S_EXEC_I;
         OPC_LOAD, OPC_STORE: nxt = S_MEM_ADDR;
         OPC_BRANCH:          nxt = S_BRANCH;
         OPC_JAL:             nxt = S_JAL;
         default:             nxt = S_TRAP;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core.
// Sequences fetch/decode/execute/mem/writeback, drives datapath selects and
// write strobes, handshakes with the unified memory port and traps on
// illegal instructions or memory timeouts.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   opcode, funct3, alu_zero   instruction fields and ALU zero flag
//   mem_ready                  memory accepts/completes the request this cycle
//   mem_req, mem_we, iord      memory request, write, address select
//   ir_write, pc_write, pc_src IR/PC load strobes and PC source
//   alu_src_a, alu_src_b, aluop  ALU operand selects and op class
//   reg_write, mem_to_reg      register file write enable and data select
//   instr_done                 one-cycle retire pulse
//   illegal, bus_err           sticky trap causes
module multicycle_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [OPC_W-1:0] opcode,
   input  logic [F3_W-1:0]  funct3,
   input  logic             alu_zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic [SEL_W-1:0] alu_src_a,
   output logic [SEL_W-1:0] alu_src_b,
   output logic [SEL_W-1:0] aluop,
   output logic             reg_write,
   output logic [SEL_W-1:0] mem_to_reg,
   output logic             instr_done,
   output logic             illegal,
   output logic             bus_err
);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic               illegal_q, illegal_d;
   logic               bus_err_q, bus_err_d;
   logic               in_mem;
   logic               timeout;

   // State, wait counter and sticky trap flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         illegal_q  <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         illegal_q  <= illegal_d;
         bus_err_q  <= bus_err_d;
      end
   end

   // Next-state logic with in-line memory wait counter
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      illegal_d  = illegal_q;
      bus_err_d  = bus_err_q;
      in_mem     = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
      // The counter holds the number of unanswered request cycles so far
      timeout    = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

      case (state_q)
         S_FETCH:    if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            state_d = decode_next(opcode);
            if (state_d == S_TRAP) illegal_d = 1'b1;
         end
         S_EXEC_R:   state_d = S_WB_ALU;
         S_EXEC_I:   state_d = S_WB_ALU;
         S_MEM_ADDR: state_d = opcode[5] ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
         S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
         S_WB_ALU:   state_d = S_FETCH;
         S_WB_MEM:   state_d = S_FETCH;
         S_BRANCH: begin
            if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
               state_d = S_FETCH;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_JAL:      state_d = S_FETCH;
         S_TRAP:     state_d = S_TRAP;
         default:    state_d = S_TRAP;
      endcase

      // Unanswered request: count, or trap once the budget is used up.
      // A mem_ready in the same cycle falls outside this branch and wins.
      if (in_mem && !mem_ready) begin
         if (timeout) begin
            state_d   = S_TRAP;
            bus_err_d = 1'b1;
         end else begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
         end
      end
   end

   // Output decode from state; everything is forced low while reset is held
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      aluop      = ALU_ADD;
      reg_write  = 1'b0;
      mem_to_reg = WB_ALUOUT;
      instr_done = 1'b0;

      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_a = SRCA_PC;
               alu_src_b = SRCB_FOUR;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            S_DECODE: begin
               // Precompute branch/jal target into ALUOut
               alu_src_a = SRCA_OLDPC;
               alu_src_b = SRCB_IMM;
            end
            S_EXEC_R: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_RS2;
               aluop     = ALU_RTYPE;
            end
            S_EXEC_I: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
               aluop     = ALU_ITYPE;
            end
            S_MEM_ADDR: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            S_MEM_WR: begin
               mem_req    = 1'b1;
               mem_we     = 1'b1;
               iord       = 1'b1;
               instr_done = mem_ready;
            end
            S_WB_ALU: begin
               reg_write  = 1'b1;
               mem_to_reg = WB_ALUOUT;
               instr_done = 1'b1;
            end
            S_WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = WB_MDR;
               instr_done = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = SRCA_RS1;
               alu_src_b = SRCB_RS2;
               aluop     = ALU_SUB;
               pc_src    = 1'b1;
               if (funct3 == F3_BEQ) begin
                  pc_write   = alu_zero;
                  instr_done = 1'b1;
               end else if (funct3 == F3_BNE) begin
                  pc_write   = ~alu_zero;
                  instr_done = 1'b1;
               end
            end
            S_JAL: begin
               reg_write  = 1'b1;
               mem_to_reg = WB_PC;
               pc_write   = 1'b1;
               pc_src     = 1'b1;
               instr_done = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign illegal = illegal_q;
   assign bus_err = bus_err_q;

endmodule
